// File: rtl/alu_exec_stage.sv
// alu_exec_stage: multi-cycle execute stage wrapped around an 8x16 register file.
// Reads Rn into A and Rm into B through the regfile read port, shifts B, applies
// the ALU op, latches C and {Z,N,V}, writes C back to Rd, then pulses done.
// Optional macro ALU_EXEC_FWD_EN: when Rn==Rm, capture both operands in LOAD_A
// and skip LOAD_B, saving one cycle.
module alu_exec_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [RW-1:0] rn,
    input  logic [RW-1:0] rm,
    input  logic [RW-1:0] rd,
    input  logic [1:0]    op,
    input  logic [1:0]    shift,
    input  logic [DW-1:0] rf_data_out,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic [DW-1:0] data_in,
    output logic [DW-1:0] c_out,
    output logic [2:0]    status,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WB, DONE} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] rn_l, rm_l, rd_l;
    logic [1:0]    op_l, shift_l;
    logic [DW-1:0] a_q, b_q, c_q;
    logic [2:0]    status_q;
    logic [DW-1:0] bs, alu_res;
    logic          alu_v;

    // State register; reset drops any in-flight command before it reaches WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and state-decoded outputs; write/done depend on state only.
    always_comb begin
        state_nxt = state;
        readnum   = '0;
        write     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = LOAD_A;
            LOAD_A: begin
                readnum = rn_l;
                busy    = 1'b1;
`ifdef ALU_EXEC_FWD_EN
                state_nxt = (rn_l == rm_l) ? EXEC : LOAD_B;
`else
                state_nxt = LOAD_B;
`endif
            end
            LOAD_B: begin
                readnum   = rm_l;
                busy      = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                busy      = 1'b1;
                state_nxt = WB;
            end
            WB: begin
                write     = 1'b1;
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE:    begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shifter and ALU on the captured operands, with signed overflow for ADD/SUB.
    always_comb begin
        case (shift_l)
            2'b00:   bs = b_q;
            2'b01:   bs = {b_q[DW-2:0], 1'b0};
            2'b10:   bs = {1'b0, b_q[DW-1:1]};
            default: bs = {b_q[DW-1], b_q[DW-1:1]};
        endcase
        alu_v = 1'b0;
        case (op_l)
            2'b00: begin
                alu_res = a_q + bs;
                alu_v   = (a_q[DW-1] == bs[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
            2'b01: begin
                alu_res = a_q - bs;
                alu_v   = (a_q[DW-1] != bs[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
            2'b10:   alu_res = a_q & bs;
            default: alu_res = ~bs;
        endcase
    end

    // Command latch, operand capture and result/status latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rn_l     <= '0;
            rm_l     <= '0;
            rd_l     <= '0;
            op_l     <= '0;
            shift_l  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rn_l    <= rn;
                    rm_l    <= rm;
                    rd_l    <= rd;
                    op_l    <= op;
                    shift_l <= shift;
                end
                LOAD_A: begin
                    a_q <= rf_data_out;
`ifdef ALU_EXEC_FWD_EN
                    if (rn_l == rm_l) b_q <= rf_data_out;
`endif
                end
                LOAD_B: b_q <= rf_data_out;
                EXEC: begin
                    c_q      <= alu_res;
                    status_q <= {alu_res == '0, alu_res[DW-1], alu_v};
                end
                default: ;
            endcase
        end
    end

    assign writenum = rd_l;
    assign data_in  = c_q;
    assign c_out    = c_q;
    assign status   = status_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural regfile with a preload mux on its write
// port, directed scenarios plus randomized commands against an arithmetic model.
module tb_alu_exec_stage;

    localparam int DW = 16;
    localparam int RW = 3;
`ifdef ALU_EXEC_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start;
    logic [RW-1:0] rn, rm, rd;
    logic [1:0]    op, shift;
    logic [DW-1:0] rf_data_out;
    logic [RW-1:0] readnum, writenum;
    logic          write;
    logic [DW-1:0] data_in, c_out;
    logic [2:0]    status;
    logic          busy, done;

    logic [DW-1:0] rf     [8];
    logic [DW-1:0] exp_rf [8];
    logic          pre_we = 1'b0;
    logic [RW-1:0] pre_num = '0;
    logic [DW-1:0] pre_data = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rn(rn), .rm(rm), .rd(rd), .op(op), .shift(shift),
        .rf_data_out(rf_data_out),
        .readnum(readnum), .writenum(writenum), .write(write), .data_in(data_in),
        .c_out(c_out), .status(status), .busy(busy), .done(done)
    );

    // Register file: bench preload has priority over the DUT write port.
    always @(posedge clk) begin
        if (pre_we)     rf[pre_num]  <= pre_data;
        else if (write) rf[writenum] <= data_in;
    end
    assign rf_data_out = rf[readnum];

    // Reference: shift and ALU from the arithmetic meaning of each op.
    function automatic void model(input logic [1:0] m_op, input logic [1:0] m_sh,
                                  input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] c, output logic [2:0] st);
        int ai, bi, bsi, r, sa, sb, sr;
        logic v;
        ai = int'(a);
        bi = int'(b);
        case (m_sh)
            2'd0:    bsi = bi;
            2'd1:    bsi = (bi * 2) % 65536;
            2'd2:    bsi = bi / 2;
            default: bsi = bi / 2 + (bi & 32768);
        endcase
        sa = (ai >= 32768) ? ai - 65536 : ai;
        sb = (bsi >= 32768) ? bsi - 65536 : bsi;
        v  = 1'b0;
        case (m_op)
            2'd0: begin r = (ai + bsi) % 65536;         sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            2'd1: begin r = (ai - bsi + 65536) % 65536; sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            2'd2:    r = ai & bsi;
            default: r = 65535 - bsi;
        endcase
        c  = 16'(r);
        st = {c == 16'h0, c[15], v};
    endfunction

    task automatic preload(input int n, input logic [15:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_num = 3'(n); pre_data = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
        exp_rf[n] = v;
    endtask

    // Issues one command and observes the following 10 cycles. extra_at >= 0
    // pulses a stray start (with junk fields) in that observation cycle.
    task automatic run_cmd(input int n_rn, input int n_rm, input int n_rd,
                           input logic [1:0] n_op, input logic [1:0] n_sh, input int extra_at,
                           output int done_edge, output int wr_edge, output int nw, output int nd);
        done_edge = -1; wr_edge = -1; nw = 0; nd = 0;
        @(negedge clk);
        start = 1'b1; rn = 3'(n_rn); rm = 3'(n_rm); rd = 3'(n_rd); op = n_op; shift = n_sh;
        @(posedge clk);
        #1 start = 1'b0;
        rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom);
        op = 2'($urandom); shift = 2'($urandom);
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            if (write) begin nw++; wr_edge = e + 1; end
            if (done)  begin nd++; done_edge = e; end
            start = (e == extra_at);
            if (e == extra_at) begin rd = 3'($urandom); op = 2'($urandom); end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, write, status, readnum} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b done=%b write=%b status=%b readnum=%0d want all 0",
                     busy, done, write, status, readnum);
        end
        checks++;
        if (c_out !== 16'h0) begin errors++; $display("FAIL reset_c: got %h want 0000", c_out); end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) preload(i, 16'h0);
    endtask

    task automatic test_add_sub();
        int de, we, nw, nd;
        preload(1, 16'h0002); preload(2, 16'h0005);
        run_cmd(1, 2, 3, 2'b00, 2'b00, -1, de, we, nw, nd);
        checks++; if (rf[3] !== 16'h0007) begin errors++; $display("FAIL add_r3: got %h want 0007", rf[3]); end
        checks++; if (status !== 3'b000) begin errors++; $display("FAIL add_status: got %b want 000", status); end
        checks++; if (we !== 4 || nw !== 1) begin errors++; $display("FAIL add_write_edge: got edge %0d count %0d want edge 4 count 1", we, nw); end
        checks++; if (de !== 4 || nd !== 1) begin errors++; $display("FAIL add_done: got edge %0d count %0d want edge 4 count 1", de, nd); end
        run_cmd(1, 2, 4, 2'b01, 2'b00, -1, de, we, nw, nd);
        checks++; if (rf[4] !== 16'hFFFD) begin errors++; $display("FAIL sub_r4: got %h want fffd", rf[4]); end
        checks++; if (status !== 3'b010) begin errors++; $display("FAIL sub_status: got %b want 010", status); end
        checks++; if (rf[1] !== 16'h0002 || rf[2] !== 16'h0005) begin errors++; $display("FAIL sub_src: got r1=%h r2=%h want 0002 0005", rf[1], rf[2]); end
        exp_rf[3] = 16'h0007; exp_rf[4] = 16'hFFFD;
    endtask

    task automatic test_overflow();
        int de, we, nw, nd;
        preload(6, 16'h7FFF); preload(7, 16'h0001);
        run_cmd(6, 7, 5, 2'b00, 2'b01, -1, de, we, nw, nd);
        checks++; if (rf[5] !== 16'h8001) begin errors++; $display("FAIL ovf_r5: got %h want 8001", rf[5]); end
        checks++; if (status !== 3'b011) begin errors++; $display("FAIL ovf_status: got %b want 011", status); end
        exp_rf[5] = 16'h8001;
    endtask

    task automatic test_and_not();
        int de, we, nw, nd;
        preload(1, 16'h00F0); preload(2, 16'h1E00);
        run_cmd(1, 2, 3, 2'b10, 2'b11, -1, de, we, nw, nd);
        checks++; if (rf[3] !== 16'h0000 || status !== 3'b100) begin errors++; $display("FAIL and_asr: got %h/%b want 0000/100", rf[3], status); end
        preload(2, 16'h8000);
        run_cmd(1, 2, 3, 2'b11, 2'b11, -1, de, we, nw, nd);
        checks++; if (rf[3] !== 16'h3FFF || status !== 3'b000) begin errors++; $display("FAIL not_asr: got %h/%b want 3fff/000", rf[3], status); end
        exp_rf[3] = 16'h3FFF;
    endtask

    task automatic test_reset_mid();
        int wcnt;
        preload(3, 16'h1234);
        wcnt = 0;
        @(negedge clk);
        start = 1'b1; rn = 3'd1; rm = 3'd2; rd = 3'd3; op = 2'b00; shift = 2'b00;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, write, status} !== 6'h00 || c_out !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b write=%b status=%b c=%h want all 0",
                     busy, done, write, status, c_out);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (write) wcnt++;
            if (i == 1) reset = 1'b0;
        end
        checks++; if (wcnt !== 0) begin errors++; $display("FAIL mid_write: got %0d write cycles want 0", wcnt); end
        checks++; if (rf[3] !== 16'h1234) begin errors++; $display("FAIL mid_r3: got %h want 1234", rf[3]); end
    endtask

    task automatic test_busy_start();
        int de, we, nw, nd;
        logic [15:0] c;
        logic [2:0]  st;
        preload(1, 16'h00F0); preload(2, 16'h8000);
        model(2'b00, 2'b00, 16'h00F0, 16'h8000, c, st);
        run_cmd(1, 2, 6, 2'b00, 2'b00, 2, de, we, nw, nd);
        checks++; if (nd !== 1 || nw !== 1) begin errors++; $display("FAIL busy_start_pulses: got done=%0d write=%0d want 1 1", nd, nw); end
        checks++; if (rf[6] !== c || status !== st) begin errors++; $display("FAIL busy_start_result: got %h/%b want %h/%b", rf[6], status, c, st); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got busy=%b want 0", busy); end
        exp_rf[6] = c;
    endtask

    task automatic test_same_reg();
        int de, we, nw, nd, lat;
        lat = FWD ? 3 : 4;
        preload(1, 16'h0002);
        run_cmd(1, 1, 2, 2'b00, 2'b00, -1, de, we, nw, nd);
        checks++; if (rf[2] !== 16'h0004) begin errors++; $display("FAIL same_r2: got %h want 0004", rf[2]); end
        checks++; if (de !== lat || we !== lat || nd !== 1) begin errors++; $display("FAIL same_latency: got done %0d write %0d want %0d", de, we, lat); end
        exp_rf[2] = 16'h0004;
    endtask

    task automatic test_random();
        int de, we, nw, nd, lat, a_n, b_n, d_n, bad;
        logic [1:0]  r_op, r_sh;
        logic [15:0] c;
        logic [2:0]  st;
        for (int it = 0; it < 30; it++) begin
            a_n = $urandom_range(7);
            b_n = ($urandom_range(3) == 0) ? a_n : $urandom_range(7);
            d_n = $urandom_range(7);
            r_op = 2'($urandom); r_sh = 2'($urandom);
            preload(a_n, 16'($urandom));
            if (b_n != a_n) preload(b_n, 16'($urandom));
            model(r_op, r_sh, exp_rf[a_n], exp_rf[b_n], c, st);
            lat = (FWD && a_n == b_n) ? 3 : 4;
            run_cmd(a_n, b_n, d_n, r_op, r_sh, -1, de, we, nw, nd);
            exp_rf[d_n] = c;
            checks++;
            if (c_out !== c || status !== st) begin
                errors++;
                $display("FAIL rand_result it=%0d op=%0d sh=%0d: got %h/%b want %h/%b", it, r_op, r_sh, c_out, status, c, st);
            end
            checks++;
            if (de !== lat || we !== lat || nd !== 1 || nw !== 1) begin
                errors++;
                $display("FAIL rand_timing it=%0d: got done %0d write %0d (%0d/%0d) want %0d", it, de, we, nd, nw, lat);
            end
            bad = 0;
            for (int i = 0; i < 8; i++) if (rf[i] !== exp_rf[i]) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rand_regfile it=%0d: got %0d wrong registers want 0 (r%0d=%h want %h)", it, bad, d_n, rf[d_n], c); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        rn = '0; rm = '0; rd = '0; op = '0; shift = '0;
        test_reset();
        test_add_sub();
        test_overflow();
        test_and_not();
        test_reset_mid();
        test_busy_start();
        test_same_reg();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
